cdb_arbiter: RTL and testbench

- Round-robin arbiter that shares the single Common Data Bus (CDB) between N functional-unit writeback sources.
- Each source offers a physical-register address/value pair with valid/ready. The arbiter grants one source per cycle into a one-entry output register.
- That register drives the CDB master side (valid, register_addr, register_val) and holds its value until the CDB slave asserts ready.
- Sits between the execution units and the CDB consumers (reservation stations, register file, ROB).

---
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the Common Data Bus between N_SRC writeback sources.
// One winner per cycle is captured into a single output register that holds until the CDB accepts it.
module cdb_arbiter #(
    parameter int N_SRC      = 4,
    parameter int PHYS_REG_W = 7,
    parameter int REG_VAL_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SRC-1:0]              src_valid,
    output logic [N_SRC-1:0]              src_ready,
    input  logic [N_SRC*PHYS_REG_W-1:0]   src_addr,
    input  logic [N_SRC*REG_VAL_W-1:0]    src_val,
    input  logic                          cdb_ready,
    output logic                          cdb_valid,
    output logic [PHYS_REG_W-1:0]         cdb_register_addr,
    output logic [REG_VAL_W-1:0]          cdb_register_val,
    output logic [15:0]                   stall_cnt
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SRC - 1);

    logic                  cdb_valid_q, cdb_valid_d;
    logic [PHYS_REG_W-1:0] cdb_addr_q, cdb_addr_d;
    logic [REG_VAL_W-1:0]  cdb_val_q, cdb_val_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;

    logic                  load;
    logic                  found;
    logic [PTR_W-1:0]      grant_idx;
    logic [PHYS_REG_W-1:0] sel_addr;
    logic [REG_VAL_W-1:0]  sel_val;
    int                    scan_idx;

    assign load = !cdb_valid_q || cdb_ready;

    // Scan from rr_ptr upward with explicit wrap so non-power-of-2 N_SRC works.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sel_addr  = '0;
        sel_val   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_SRC) begin
                scan_idx = scan_idx - N_SRC;
            end
            if (!found && src_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(scan_idx);
                sel_addr  = src_addr[scan_idx*PHYS_REG_W +: PHYS_REG_W];
                sel_val   = src_val[scan_idx*REG_VAL_W +: REG_VAL_W];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (rst_n && load && found) begin
            src_ready = N_SRC'(1) << grant_idx;
        end
    end

    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_addr_d  = cdb_addr_q;
        cdb_val_d   = cdb_val_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        if (load) begin
            if (found) begin
                cdb_valid_d = 1'b1;
                cdb_addr_d  = sel_addr;
                cdb_val_d   = sel_val;
                rr_ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end else begin
                cdb_valid_d = 1'b0;
            end
        end else if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Reset discards any pending broadcast immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_addr_q  <= '0;
            cdb_val_q   <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_addr_q  <= cdb_addr_d;
            cdb_val_q   <= cdb_val_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cdb_valid         = cdb_valid_q;
    assign cdb_register_addr = cdb_addr_q;
    assign cdb_register_val  = cdb_val_q;
    assign stall_cnt         = stall_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: reset, round-robin order, single source,
// wrap with gaps, backpressure with stall counting, and asynchronous reset mid-stall.
module tb_cdb_arbiter;

   localparam int N_SRC      = 4;
   localparam int PHYS_REG_W = 7;
   localparam int REG_VAL_W  = 32;

   logic                        clk;
   logic                        rst_n;
   logic [N_SRC-1:0]            src_valid;
   logic [N_SRC-1:0]            src_ready;
   logic [N_SRC*PHYS_REG_W-1:0] src_addr;
   logic [N_SRC*REG_VAL_W-1:0]  src_val;
   logic                        cdb_ready;
   logic                        cdb_valid;
   logic [PHYS_REG_W-1:0]       cdb_register_addr;
   logic [REG_VAL_W-1:0]        cdb_register_val;
   logic [15:0]                 stall_cnt;

   int checkCount;
   int passCount;

   cdb_arbiter #(
      .N_SRC(N_SRC),
      .PHYS_REG_W(PHYS_REG_W),
      .REG_VAL_W(REG_VAL_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .src_valid(src_valid),
      .src_ready(src_ready),
      .src_addr(src_addr),
      .src_val(src_val),
      .cdb_ready(cdb_ready),
      .cdb_valid(cdb_valid),
      .cdb_register_addr(cdb_register_addr),
      .cdb_register_val(cdb_register_val),
      .stall_cnt(stall_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Loads one source's address/value slot in the flattened buses
   task automatic setSrc(input int idx, input logic [PHYS_REG_W-1:0] a, input logic [REG_VAL_W-1:0] v);
      src_addr[idx*PHYS_REG_W +: PHYS_REG_W] = a;
      src_val[idx*REG_VAL_W +: REG_VAL_W]    = v;
   endtask

   // Drives request/ready inputs and lets combinational outputs settle
   task automatic applyStimulus(input logic [N_SRC-1:0] valid, input logic ready);
      src_valid = valid;
      cdb_ready = ready;
      #1;
   endtask

   // Advances one rising edge and samples 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, counts passes, reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence with hand-computed expectations
   initial begin
      checkCount = 0;
      passCount  = 0;
      src_addr   = '0;
      src_val    = '0;
      for (int i = 0; i < N_SRC; i++) begin
         setSrc(i, PHYS_REG_W'(10 + i), 32'hA000_0000 + 32'(i));
      end
      rst_n = 1'b0;
      applyStimulus(4'b1111, 1'b1);
      #11;

      checkOutput("reset_src_ready", 32'(src_ready), 32'h0);
      checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'h0);
      checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'h0);
      checkOutput("reset_addr", 32'(cdb_register_addr), 32'h0);
      checkOutput("reset_val", cdb_register_val, 32'h0);

      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("rr_grant_%0d", k), 32'(src_ready), 32'(1) << (k % 4));
         tick();
         checkOutput($sformatf("rr_valid_%0d", k), 32'(cdb_valid), 32'h1);
         checkOutput($sformatf("rr_addr_%0d", k), 32'(cdb_register_addr), 32'(10 + (k % 4)));
         checkOutput($sformatf("rr_val_%0d", k), cdb_register_val, 32'hA000_0000 + 32'(k % 4));
      end

      setSrc(2, 7'd17, 32'hDEAD_BEEF);
      applyStimulus(4'b0100, 1'b1);
      checkOutput("single_src_ready", 32'(src_ready), 32'h4);
      tick();
      checkOutput("single_valid", 32'(cdb_valid), 32'h1);
      checkOutput("single_addr", 32'(cdb_register_addr), 32'd17);
      checkOutput("single_val", cdb_register_val, 32'hDEAD_BEEF);

      applyStimulus(4'b0000, 1'b1);
      checkOutput("idle_src_ready", 32'(src_ready), 32'h0);
      tick();
      checkOutput("idle_bubble_valid", 32'(cdb_valid), 32'h0);

      applyStimulus(4'b0011, 1'b1);
      checkOutput("wrap_grant_src0", 32'(src_ready), 32'h1);
      tick();
      checkOutput("wrap_addr_src0", 32'(cdb_register_addr), 32'd10);
      checkOutput("wrap_grant_src1", 32'(src_ready), 32'h2);
      tick();
      checkOutput("wrap_addr_src1", 32'(cdb_register_addr), 32'd11);

      applyStimulus(4'b1111, 1'b0);
      checkOutput("bp_src_ready_start", 32'(src_ready), 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("bp_hold_valid_%0d", k), 32'(cdb_valid), 32'h1);
         checkOutput($sformatf("bp_hold_addr_%0d", k), 32'(cdb_register_addr), 32'd11);
         checkOutput($sformatf("bp_src_ready_%0d", k), 32'(src_ready), 32'h0);
      end
      checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd5);

      applyStimulus(4'b1111, 1'b1);
      checkOutput("bp_release_grant", 32'(src_ready), 32'h4);
      tick();
      checkOutput("bp_release_addr", 32'(cdb_register_addr), 32'd17);
      checkOutput("bp_release_val", cdb_register_val, 32'hDEAD_BEEF);
      checkOutput("bp_release_stall", 32'(stall_cnt), 32'd5);

      applyStimulus(4'b1111, 1'b0);
      tick();
      tick();
      checkOutput("stall_before_reset", 32'(stall_cnt), 32'd7);
      checkOutput("valid_before_reset", 32'(cdb_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", 32'(cdb_valid), 32'h0);
      checkOutput("async_reset_stall", 32'(stall_cnt), 32'h0);
      checkOutput("async_reset_src_ready", 32'(src_ready), 32'h0);

      applyStimulus(4'b0000, 1'b1);
      rst_n = 1'b1;
      tick();
      checkOutput("post_reset_no_broadcast", 32'(cdb_valid), 32'h0);

      applyStimulus(4'b1000, 1'b1);
      checkOutput("post_reset_grant_src3", 32'(src_ready), 32'h8);
      tick();
      checkOutput("post_reset_addr_src3", 32'(cdb_register_addr), 32'd13);
      checkOutput("post_reset_val_src3", cdb_register_val, 32'hA000_0003);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
